// File: rtl/run_sequencer.sv
// run_sequencer: program-run controller sitting between the Start/Ack
// handshake and the core fetch path. Selects a program entry point, loads
// the PC while armed, gates execution, detects completion on Halt, applies
// an optional watchdog and keeps per-run cycle and completed-run counters.
module run_sequencer #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned NPROG   = 3,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned SEL_W  = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [SEL_W-1:0]      ProgSel,
  input  logic [NPROG*PC_W-1:0] ProgBase,
  input  logic                  Halt,
  output logic                  Run,
  output logic                  PcLoad,
  output logic [PC_W-1:0]       PcLoadVal,
  output logic                  Ack,
  output logic                  TimedOut,
  output logic [CNT_W-1:0]      CycleCount,
  output logic [7:0]            ProgsDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The watchdog only exists when a limit is given and the limit is
  // reachable by a CNT_W-bit counter; otherwise it can never fire.
  localparam bit WD_EN = (TIMEOUT != 0) &&
                         (64'(TIMEOUT) <= (64'd1 << CNT_W));
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NPROG - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cycleCount;
  logic               r_timedOut;
  logic [7:0]         r_progsDone;
  logic [SEL_W-1:0]   w_slot;
  logic [PC_W-1:0]    w_slotBase;
  logic               w_watchdogHit;
  logic               w_haltEnd;
  logic               w_timeoutEnd;

  assign w_watchdogHit = WD_EN && (r_cycleCount == WD_LAST);

  // Clamp an out-of-range selection to the last slot and pick its base.
  always_comb begin
    w_slot = ProgSel;
    if (ProgSel > LAST_SLOT) begin
      w_slot = LAST_SLOT;
    end
    w_slotBase = ProgBase[32'(w_slot) * PC_W +: PC_W];
  end

  // State register; reset forces IDLE regardless of what is running.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and state-decoded outputs; Start in RUN beats Halt and timeout.
  always_comb begin
    w_nextState  = r_state;
    Run          = 1'b0;
    PcLoad       = 1'b0;
    PcLoadVal    = '0;
    Ack          = 1'b0;
    w_haltEnd    = 1'b0;
    w_timeoutEnd = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_nextState = ARMED;
        end
      end
      ARMED: begin
        PcLoad    = 1'b1;
        PcLoadVal = w_slotBase;
        if (!Start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        Run = 1'b1;
        if (Start) begin
          w_nextState = ARMED;
        end else if (Halt) begin
          w_haltEnd   = 1'b1;
          w_nextState = DONE;
        end else if (w_watchdogHit) begin
          w_timeoutEnd = 1'b1;
          w_nextState  = DONE;
        end
      end
      DONE: begin
        Ack = 1'b1;
        if (Start) begin
          w_nextState = ARMED;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Run statistics: cleared while armed, counted in RUN, frozen elsewhere.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_cycleCount <= '0;
      r_timedOut   <= 1'b0;
      r_progsDone  <= '0;
    end else begin
      case (r_state)
        ARMED: begin
          r_cycleCount <= '0;
          r_timedOut   <= 1'b0;
        end
        RUN: begin
          if (r_cycleCount != '1) begin
            r_cycleCount <= r_cycleCount + 1'b1;
          end
          if (w_timeoutEnd) begin
            r_timedOut <= 1'b1;
          end
          if (w_haltEnd) begin
            r_progsDone <= r_progsDone + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign CycleCount = r_cycleCount;
  assign TimedOut   = r_timedOut;
  assign ProgsDone  = r_progsDone;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed test of run_sequencer. Two instances share all
// inputs: one with an 8-cycle watchdog, one with the watchdog disabled.
// Expected run results are queued at launch and checked when Ack appears.
module tb_run_sequencer;

  logic        Clk;
  logic        ResetN;
  logic        Start;
  logic [1:0]  ProgSel;
  logic [29:0] ProgBase;
  logic        Halt;

  logic        Run, PcLoad, Ack, TimedOut;
  logic [9:0]  PcLoadVal;
  logic [15:0] CycleCount;
  logic [7:0]  ProgsDone;

  logic        run0, pcLoad0, ack0, timedOut0;
  logic [9:0]  pcLoadVal0;
  logic [15:0] cycleCount0;
  logic [7:0]  progsDone0;

  typedef struct {
    int cyc;
    int progs;
    int to;
  } expRun_t;

  expRun_t sb[$];
  int      total = 0;
  int      bad   = 0;
  int      baseTable[3] = '{0, 100, 200};

  run_sequencer #(.PC_W(10), .NPROG(3), .CNT_W(16), .TIMEOUT(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .ProgSel(ProgSel),
    .ProgBase(ProgBase), .Halt(Halt), .Run(Run), .PcLoad(PcLoad),
    .PcLoadVal(PcLoadVal), .Ack(Ack), .TimedOut(TimedOut),
    .CycleCount(CycleCount), .ProgsDone(ProgsDone)
  );

  run_sequencer #(.PC_W(10), .NPROG(3), .CNT_W(16), .TIMEOUT(0)) dut0 (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .ProgSel(ProgSel),
    .ProgBase(ProgBase), .Halt(Halt), .Run(run0), .PcLoad(pcLoad0),
    .PcLoadVal(pcLoadVal0), .Ack(ack0), .TimedOut(timedOut0),
    .CycleCount(cycleCount0), .ProgsDone(progsDone0)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout observed=stalled expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int baseOf(input logic [1:0] sel);
    int idx;
    idx = (sel >= 2'd3) ? 2 : int'(sel);
    return baseTable[idx];
  endfunction

  // Arm with the given slot for armCycles cycles, then release Start.
  task automatic applyStimulus(input logic [1:0] sel, input int armCycles);
    int b;
    b       = baseOf(sel);
    ProgSel = sel;
    Start   = 1'b1;
    for (int i = 0; i < armCycles; i++) begin
      tick();
      checkOutput("armPcLoad", 32'(PcLoad), 1);
      checkOutput("armPcVal", 32'(PcLoadVal), b);
      checkOutput("armRun", 32'(Run), 0);
    end
    Start = 1'b0;
    tick();
  endtask

  task automatic runHalt(input int n);
    for (int i = 1; i <= n; i++) begin
      checkOutput("runRun", 32'(Run), 1);
      checkOutput("runAck", 32'(Ack), 0);
      Halt = (i == n);
      tick();
    end
    Halt = 1'b0;
  endtask

  // Bounded wait for Ack, then compare against the oldest queued run.
  task automatic waitAck();
    int      waited;
    expRun_t e;
    waited = 0;
    while (!Ack && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("ackSeen", 32'(Ack), 1);
    checkOutput("ackLatency", waited, 0);
    checkOutput("ackRunLow", 32'(Run), 0);
    checkOutput("sbNonEmpty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("sbCycleCount", 32'(CycleCount), e.cyc);
      checkOutput("sbProgsDone", 32'(ProgsDone), e.progs);
      checkOutput("sbTimedOut", 32'(TimedOut), e.to);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Flags"}, 32'({Run, PcLoad, Ack, TimedOut}), 0);
    checkOutput({tag, "PcVal"}, 32'(PcLoadVal), 0);
    checkOutput({tag, "Cycles"}, 32'(CycleCount), 0);
    checkOutput({tag, "Progs"}, 32'(ProgsDone), 0);
  endtask

  initial begin
    ResetN   = 1'b0;
    Start    = 1'b0;
    Halt     = 1'b0;
    ProgSel  = 2'd0;
    ProgBase = {10'd200, 10'd100, 10'd0};

    // Reset then idle
    tick();
    tick();
    checkAllZero("reset");
    ResetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkAllZero("idle");
    end

    // Normal run: slot 1, armed 3 cycles, halt on the 5th RUN cycle
    sb.push_back('{5, 1, 0});
    applyStimulus(2'd1, 3);
    runHalt(5);
    waitAck();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ackHold", 32'(Ack), 1);
      checkOutput("ackHoldCycles", 32'(CycleCount), 5);
    end

    // Out-of-range select and combinational PcLoadVal, back-to-back from DONE
    Start   = 1'b1;
    ProgSel = 2'd3;
    tick();
    checkOutput("clampPcVal", 32'(PcLoadVal), 200);
    ProgSel = 2'd1;
    #1;
    checkOutput("combPcVal", 32'(PcLoadVal), 100);
    ProgSel = 2'd3;
    #1;
    checkOutput("clampPcVal2", 32'(PcLoadVal), 200);
    Start = 1'b0;
    tick();
    sb.push_back('{2, 2, 0});
    runHalt(2);
    waitAck();

    // Watchdog: no Halt, dut ends after 8 RUN cycles, dut0 keeps running
    sb.push_back('{8, 2, 1});
    applyStimulus(2'd0, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("wdRun", 32'(Run), 1);
      tick();
    end
    waitAck();
    checkOutput("wdOffStillRun", 32'(run0), 1);
    checkOutput("wdOffNoTimeout", 32'(timedOut0), 0);

    // Next Start clears TimedOut and CycleCount
    Start = 1'b1;
    tick();
    tick();
    checkOutput("rearmTimedOut", 32'(TimedOut), 0);
    checkOutput("rearmCycles", 32'(CycleCount), 0);
    checkOutput("rearmCycles0", 32'(cycleCount0), 0);

    // Abort: Start together with Halt in RUN goes back to ARMED
    Start = 1'b0;
    tick();
    checkOutput("abortRun1", 32'(Run), 1);
    tick();
    checkOutput("abortRun2", 32'(Run), 1);
    Start = 1'b1;
    Halt  = 1'b1;
    tick();
    Halt = 1'b0;
    checkOutput("abortPcLoad", 32'(PcLoad), 1);
    checkOutput("abortAck", 32'(Ack), 0);
    checkOutput("abortRun", 32'(Run), 0);
    tick();
    checkOutput("abortCycles", 32'(CycleCount), 0);
    checkOutput("abortProgs", 32'(ProgsDone), 2);
    Start = 1'b0;
    tick();
    sb.push_back('{3, 3, 0});
    runHalt(3);
    waitAck();

    // Reset during RUN cycle 3
    applyStimulus(2'd2, 1);
    checkOutput("midRun1", 32'(Run), 1);
    tick();
    checkOutput("midRun2", 32'(Run), 1);
    tick();
    ResetN = 1'b0;
    tick();
    checkAllZero("midReset");
    checkOutput("midReset0", 32'({run0, pcLoad0, ack0, timedOut0}), 0);
    checkOutput("midReset0Progs", 32'(progsDone0), 0);
    ResetN = 1'b1;
    tick();
    checkAllZero("postReset");

    // Fresh run after reset
    sb.push_back('{4, 1, 0});
    applyStimulus(2'd2, 2);
    runHalt(4);
    waitAck();

    // Long run: dut times out at 8, dut0 completes by Halt at 12
    sb.push_back('{8, 1, 1});
    applyStimulus(2'd1, 1);
    for (int i = 1; i <= 12; i++) begin
      if (i <= 8) begin
        checkOutput("longRun", 32'(Run), 1);
      end else begin
        checkOutput("longAckEarly", 32'({Ack, Run}), 2);
      end
      checkOutput("longRun0", 32'(run0), 1);
      Halt = (i == 12);
      tick();
    end
    Halt = 1'b0;
    checkOutput("long0Ack", 32'(ack0), 1);
    checkOutput("long0Run", 32'(run0), 0);
    checkOutput("long0Cycles", 32'(cycleCount0), 12);
    checkOutput("long0Progs", 32'(progsDone0), 2);
    checkOutput("long0TimedOut", 32'(timedOut0), 0);
    waitAck();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
